// File: rtl/state_control_multi.sv
// Top-level search sequencer for one FM-index iteration:
// GET_PARAM -> GET_DATA_1 -> [GET_OCC x OCC_BEATS] -> EX -> WRITE_BACK x WB_CYCLES.
// It adds wait timeouts that lead to ERROR, abort, an iteration counter and
// state-entry pulses.
module state_control_multi #(
  parameter int OCC_BEATS = 2,
  parameter int WB_CYCLES = 1,
  parameter int TIMEOUT   = 255,
  parameter int ITER_W    = 16,
  localparam int OB_W     = (OCC_BEATS > 1) ? $clog2(OCC_BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              is_start,
  input  logic              is_finish,
  input  logic              is_find,
  input  logic              is_get_data_in_Occ,
  input  logic              ex_done,
  input  logic              abort,
  output logic [3:0]        state,
  output logic              state_enter,
  output logic [OB_W-1:0]   occ_beat,
  output logic [ITER_W-1:0] iter_count,
  output logic              busy,
  output logic [3:0]        err_state
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_GET_PARAM  = 4'd1,
    S_GET_DATA_1 = 4'd2,
    S_GET_OCC    = 4'd3,
    S_EX         = 4'd5,
    S_WRITE_BACK = 4'd6,
    S_DONE       = 4'd7,
    S_ERROR      = 4'd8
  } state_t;

  // One shared in-state cycle counter covers the wait, Occ-beat and
  // write-back counts. Only one of them is live in any state, and it is
  // cleared whenever the state changes.
  localparam int CNT_MAX_A = (TIMEOUT > OCC_BEATS) ? TIMEOUT : OCC_BEATS;
  localparam int CNT_MAX   = (CNT_MAX_A > WB_CYCLES) ? CNT_MAX_A : WB_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] OCC_LAST = CNT_W'(OCC_BEATS - 1);
  localparam logic [CNT_W-1:0] WB_LAST  = CNT_W'(WB_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ITER_W-1:0] iter_reg, iter_next;
  logic [3:0]        err_reg, err_next;
  logic              enter_reg;
  logic              timeout_hit;

  // Next-state, counter and bookkeeping logic in priority order: abort, then
  // finish, then the normal flow.
  always_comb begin
    state_next  = state_reg;
    iter_next   = iter_reg;
    err_next    = err_reg;
    timeout_hit = (TIMEOUT != 0) && (cnt_reg == TMO_LAST);
    if (abort) begin
      state_next = S_IDLE;
      iter_next  = '0;
      err_next   = '0;
    end else if (is_finish && state_reg != S_IDLE && state_reg != S_ERROR) begin
      state_next = S_DONE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (is_start) begin
            state_next = S_GET_PARAM;
            iter_next  = '0;
          end
        end
        S_GET_PARAM: begin
          if (is_find) begin
            state_next = S_GET_DATA_1;
          end else if (timeout_hit) begin
            state_next = S_ERROR;
            err_next   = S_GET_PARAM;
          end
        end
        S_GET_DATA_1: state_next = is_get_data_in_Occ ? S_GET_OCC : S_EX;
        S_GET_OCC: begin
          if (cnt_reg == OCC_LAST) state_next = S_EX;
        end
        S_EX: begin
          if (ex_done) begin
            state_next = S_WRITE_BACK;
          end else if (timeout_hit) begin
            state_next = S_ERROR;
            err_next   = S_EX;
          end
        end
        S_WRITE_BACK: begin
          if (cnt_reg == WB_LAST) begin
            state_next = S_GET_PARAM;
            if (iter_reg != {ITER_W{1'b1}}) iter_next = iter_reg + ITER_W'(1);
          end
        end
        S_DONE:  state_next = S_DONE;
        S_ERROR: state_next = S_ERROR;
        default: state_next = S_IDLE;
      endcase
    end
    cnt_next = (state_next == state_reg) ? cnt_reg + CNT_W'(1) : '0;
  end

  // State, counters and the entry pulse, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      iter_reg  <= '0;
      err_reg   <= '0;
      enter_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      iter_reg  <= iter_next;
      err_reg   <= err_next;
      enter_reg <= (state_next != state_reg);
    end
  end

  assign state       = state_reg;
  assign state_enter = enter_reg;
  assign occ_beat    = (state_reg == S_GET_OCC) ? cnt_reg[OB_W-1:0] : '0;
  assign iter_count  = iter_reg;
  assign err_state   = err_reg;
  assign busy        = (state_reg != S_IDLE) && (state_reg != S_DONE) && (state_reg != S_ERROR);

endmodule

// File: tb/tb_state_control_multi.sv
// Bench for state_control_multi. It runs two instances on shared inputs:
// u_a (OCC_BEATS=3, WB_CYCLES=2, TIMEOUT=4, ITER_W=2) and u_b (TIMEOUT=0,
// other parameters at their defaults). Directed scenarios are followed by a
// randomized run that checks both instances against a cycle-count model.
module tb_state_control_multi;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, is_start = 1'b0, is_finish = 1'b0, is_find = 1'b0;
  logic is_get_data_in_Occ = 1'b0, ex_done = 1'b0, abort = 1'b0;

  logic [3:0]  a_state, b_state, a_err, b_err;
  logic        a_enter, b_enter, a_busy, b_busy;
  logic [1:0]  a_beat, a_iter;
  logic [0:0]  b_beat;
  logic [15:0] b_iter;

  int n_vec = 0;
  int n_err = 0;

  state_control_multi #(.OCC_BEATS(3), .WB_CYCLES(2), .TIMEOUT(4), .ITER_W(2)) u_a (
    .clk(clk), .rst_n(rst_n), .is_start(is_start), .is_finish(is_finish), .is_find(is_find),
    .is_get_data_in_Occ(is_get_data_in_Occ), .ex_done(ex_done), .abort(abort),
    .state(a_state), .state_enter(a_enter), .occ_beat(a_beat), .iter_count(a_iter),
    .busy(a_busy), .err_state(a_err));

  state_control_multi #(.TIMEOUT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .is_start(is_start), .is_finish(is_finish), .is_find(is_find),
    .is_get_data_in_Occ(is_get_data_in_Occ), .ex_done(ex_done), .abort(abort),
    .state(b_state), .state_enter(b_enter), .occ_beat(b_beat), .iter_count(b_iter),
    .busy(b_busy), .err_state(b_err));

  // Model: current stage, number of earlier cycles spent in it, iteration
  // count, latched error stage and the entry flag.
  typedef struct {
    int st;
    int cnt;
    int iter;
    int err;
    bit enter;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t step(mdl_t m, int occ_b, int wb_c, int tmo, int imax);
    mdl_t n = m;
    bit last_wait;
    if (!rst_n) begin
      n = '{0, 0, 0, 0, 1'b1};
      return n;
    end
    last_wait = (tmo != 0) && (m.cnt + 1 == tmo);
    if (abort) begin
      n.st = 0; n.iter = 0; n.err = 0;
    end else if (is_finish && m.st != 0 && m.st != 8) begin
      n.st = 7;
    end else begin
      case (m.st)
        0: if (is_start) begin n.st = 1; n.iter = 0; end
        1: if (is_find) n.st = 2; else if (last_wait) begin n.st = 8; n.err = 1; end
        2: n.st = is_get_data_in_Occ ? 3 : 5;
        3: if (m.cnt + 1 == occ_b) n.st = 5;
        5: if (ex_done) n.st = 6; else if (last_wait) begin n.st = 8; n.err = 5; end
        6: if (m.cnt + 1 == wb_c) begin n.st = 1; n.iter = (m.iter < imax) ? m.iter + 1 : imax; end
        default: n.st = m.st;
      endcase
    end
    n.enter = (n.st != m.st);
    n.cnt   = n.enter ? 0 : m.cnt + 1;
    return n;
  endfunction

  // Advance one clock: the models see the inputs that the DUTs sample at the edge.
  task automatic tick();
    mdl_t na, nb;
    na = step(ma, 3, 2, 4, 3);
    nb = step(mb, 2, 1, 0, 65535);
    @(posedge clk);
    #1;
    ma = na;
    mb = nb;
  endtask

  task automatic clear_inputs();
    is_start = 0; is_finish = 0; is_find = 0; is_get_data_in_Occ = 0; ex_done = 0; abort = 0;
  endtask

  task automatic go_idle();
    clear_inputs();
    abort = 1;
    tick();
    abort = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    n_vec++; if (a_state !== 4'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", a_state); end
    n_vec++; if (a_enter !== 1'b1) begin n_err++; $display("FAIL reset_enter got=%0b exp=1", a_enter); end
    n_vec++; if ({a_iter, a_err, a_beat, a_busy} !== 9'd0) begin n_err++; $display("FAIL reset_outs got=%0h exp=0", {a_iter, a_err, a_beat, a_busy}); end
    tick();
    n_vec++; if (a_state !== 4'd0 || a_enter !== 1'b0) begin n_err++; $display("FAIL reset_idle_hold state=%0d enter=%0b exp 0/0", a_state, a_enter); end
  endtask

  task automatic test_basic();
    int est[6] = '{1, 2, 5, 6, 6, 1};
    bit een[6] = '{1, 1, 1, 1, 0, 1};
    go_idle();
    is_start = 1; is_find = 1; ex_done = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++; if (a_state !== 4'(est[i]) || a_enter !== een[i]) begin
        n_err++; $display("FAIL basic_seq step=%0d state=%0d enter=%0b exp %0d/%0b", i, a_state, a_enter, est[i], een[i]);
      end
    end
    n_vec++; if (a_iter !== 2'd1) begin n_err++; $display("FAIL basic_iter got=%0d exp=1", a_iter); end
  endtask

  task automatic test_occ_path();
    int est[9] = '{1, 2, 3, 3, 3, 5, 6, 6, 1};
    int ebt[9] = '{0, 0, 0, 1, 2, 0, 0, 0, 0};
    bit een[9] = '{1, 1, 1, 0, 0, 1, 1, 0, 1};
    go_idle();
    is_start = 1; is_find = 1; is_get_data_in_Occ = 1; ex_done = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_vec++; if (a_state !== 4'(est[i]) || a_beat !== 2'(ebt[i]) || a_enter !== een[i]) begin
        n_err++; $display("FAIL occ_seq step=%0d state=%0d beat=%0d enter=%0b exp %0d/%0d/%0b",
                          i, a_state, a_beat, a_enter, est[i], ebt[i], een[i]);
      end
    end
  endtask

  task automatic test_timeout();
    go_idle();
    is_start = 1;
    tick();
    is_start = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (a_state !== 4'd1) begin n_err++; $display("FAIL tmo_wait cyc=%0d got=%0d exp=1", i + 2, a_state); end
    end
    tick();
    n_vec++; if (a_state !== 4'd8) begin n_err++; $display("FAIL tmo_error got=%0d exp=8", a_state); end
    n_vec++; if (a_err !== 4'd1 || a_busy !== 1'b0 || a_enter !== 1'b1) begin
      n_err++; $display("FAIL tmo_outs err=%0d busy=%0b enter=%0b exp 1/0/1", a_err, a_busy, a_enter);
    end
    is_finish = 1;
    tick();
    is_finish = 0;
    n_vec++; if (a_state !== 4'd8) begin n_err++; $display("FAIL tmo_ignore_finish got=%0d exp=8", a_state); end
    go_idle();
    is_start = 1;
    tick();
    is_start = 0;
    repeat (3) tick();
    is_find = 1;
    tick();
    n_vec++; if (a_state !== 4'd2) begin n_err++; $display("FAIL tmo_exit_wins got=%0d exp=2", a_state); end
  endtask

  task automatic test_finish_abort();
    go_idle();
    is_start = 1; is_find = 1; is_get_data_in_Occ = 1;
    repeat (4) tick();
    n_vec++; if (a_state !== 4'd3 || a_beat !== 2'd1) begin n_err++; $display("FAIL fin_beat1 state=%0d beat=%0d exp 3/1", a_state, a_beat); end
    is_finish = 1;
    tick();
    is_finish = 0;
    n_vec++; if (a_state !== 4'd7 || a_busy !== 1'b0 || a_enter !== 1'b1) begin
      n_err++; $display("FAIL fin_done state=%0d busy=%0b enter=%0b exp 7/0/1", a_state, a_busy, a_enter);
    end
    for (int i = 0; i < 4; i++) begin
      is_start = i[0];
      tick();
      n_vec++; if (a_state !== 4'd7 || a_enter !== 1'b0) begin n_err++; $display("FAIL fin_sticky i=%0d state=%0d enter=%0b exp 7/0", i, a_state, a_enter); end
    end
    abort = 1;
    tick();
    abort = 0;
    n_vec++; if (a_state !== 4'd0 || a_iter !== 2'd0) begin n_err++; $display("FAIL fin_abort state=%0d iter=%0d exp 0/0", a_state, a_iter); end
  endtask

  task automatic test_iter_sat();
    int eit[5] = '{1, 2, 3, 3, 3};
    go_idle();
    is_start = 1; is_find = 1; ex_done = 1;
    tick();
    is_start = 0;
    for (int k = 0; k < 5; k++) begin
      repeat (5) tick();
      n_vec++; if (a_state !== 4'd1 || a_iter !== 2'(eit[k])) begin
        n_err++; $display("FAIL iter_sat k=%0d state=%0d iter=%0d exp 1/%0d", k, a_state, a_iter, eit[k]);
      end
    end
    ex_done = 0;
    repeat (3) tick();
    n_vec++; if (a_state !== 4'd5) begin n_err++; $display("FAIL iter_mid_ex got=%0d exp=5", a_state); end
    rst_n = 0;
    tick();
    rst_n = 1;
    n_vec++; if (a_state !== 4'd0 || a_enter !== 1'b1 || {a_iter, a_err, a_beat, a_busy} !== 9'd0) begin
      n_err++; $display("FAIL iter_reset state=%0d enter=%0b rest=%0h exp 0/1/0", a_state, a_enter, {a_iter, a_err, a_beat, a_busy});
    end
  endtask

  task automatic test_abort_finish_ex();
    go_idle();
    is_start = 1; is_find = 1;
    repeat (3) tick();
    n_vec++; if (a_state !== 4'd5) begin n_err++; $display("FAIL af_in_ex got=%0d exp=5", a_state); end
    abort = 1; is_finish = 1;
    tick();
    clear_inputs();
    n_vec++; if (a_state !== 4'd0) begin n_err++; $display("FAIL af_priority got=%0d exp=0", a_state); end
  endtask

  task automatic test_no_timeout();
    int bad = 0;
    go_idle();
    is_start = 1; is_find = 1;
    repeat (3) tick();
    clear_inputs();
    for (int i = 0; i < 1000; i++) begin
      tick();
      n_vec++;
      if (b_state !== 4'd5 || b_err !== 4'd0) begin
        n_err++; bad++;
        if (bad < 5) $display("FAIL notmo_hold cyc=%0d state=%0d err=%0d exp 5/0", i, b_state, b_err);
      end
    end
    ex_done = 1;
    tick();
    ex_done = 0;
    n_vec++; if (b_state !== 4'd6) begin n_err++; $display("FAIL notmo_exit got=%0d exp=6", b_state); end
  endtask

  task automatic test_random();
    int eb;
    clear_inputs();
    rst_n = 0;
    tick();
    for (int c = 0; c < 3000; c++) begin
      rst_n              = ($urandom_range(0, 199) != 0);
      abort              = ($urandom_range(0, 59) == 0);
      is_finish          = ($urandom_range(0, 39) == 0);
      is_start           = 1'($urandom_range(0, 1));
      is_find            = ($urandom_range(0, 9) < 6);
      is_get_data_in_Occ = 1'($urandom_range(0, 1));
      ex_done            = 1'($urandom_range(0, 1));
      tick();
      n_vec++; if (a_state !== 4'(ma.st) || a_enter !== ma.enter) begin
        n_err++; $display("FAIL rnd_a_state c=%0d state=%0d enter=%0b exp %0d/%0b", c, a_state, a_enter, ma.st, ma.enter);
      end
      eb = (ma.st == 3) ? ma.cnt : 0;
      n_vec++; if (a_beat !== 2'(eb) || a_iter !== 2'(ma.iter) || a_err !== 4'(ma.err)) begin
        n_err++; $display("FAIL rnd_a_data c=%0d beat=%0d iter=%0d err=%0d exp %0d/%0d/%0d", c, a_beat, a_iter, a_err, eb, ma.iter, ma.err);
      end
      n_vec++; if (a_busy !== (ma.st inside {1, 2, 3, 5, 6})) begin n_err++; $display("FAIL rnd_a_busy c=%0d got=%0b st=%0d", c, a_busy, ma.st); end
      n_vec++; if (b_state !== 4'(mb.st) || b_enter !== mb.enter) begin
        n_err++; $display("FAIL rnd_b_state c=%0d state=%0d enter=%0b exp %0d/%0b", c, b_state, b_enter, mb.st, mb.enter);
      end
      eb = (mb.st == 3) ? mb.cnt : 0;
      n_vec++; if (b_beat !== 1'(eb) || b_iter !== 16'(mb.iter) || b_err !== 4'(mb.err)) begin
        n_err++; $display("FAIL rnd_b_data c=%0d beat=%0d iter=%0d err=%0d exp %0d/%0d/%0d", c, b_beat, b_iter, b_err, eb, mb.iter, mb.err);
      end
      n_vec++; if (b_busy !== (mb.st inside {1, 2, 3, 5, 6})) begin n_err++; $display("FAIL rnd_b_busy c=%0d got=%0b st=%0d", c, b_busy, mb.st); end
    end
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_occ_path();
    test_timeout();
    test_finish_abort();
    test_iter_sat();
    test_abort_finish_ex();
    test_no_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
